// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the board UART receive path: bus decode addresses and FSM state type.
package uart_receiver_pkg;

    localparam logic [31:0] uart_rx_data_address   = 32'h0000_8008;
    localparam logic [31:0] uart_rx_status_address = 32'h0000_800C;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

endpackage

// File: rtl/uart_receiver_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is read combinationally from storage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM, sticky error flags, FWFT receive FIFO.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    input  logic                          rd_en,
    input  logic                          err_clear,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic           sync_p0;
    logic           sync_p1;
    logic           rxs_prev;
    logic           rxs;
    uart_rx_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;
    logic           push_p;
    logic           stop_bad;
    logic           overrun_evt;
    logic           fifo_full;
    logic           fifo_empty;

    // Stage p0/p1: two-flop synchronizer; flops idle high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0  <= 1'b1;
            sync_p1  <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync_p0  <= rxd;
            sync_p1  <= sync_p0;
            rxs_prev <= sync_p1;
        end
    end

    assign rxs = sync_p1;

    // Frame FSM: start confirmed at half a bit, data and stop sampled one full bit later each.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            push_p  <= 1'b0;
        end else begin
            push_p <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rxs && rxs_prev) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        push_p <= rxs;
                        state  <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign stop_bad    = (state == RX_STOP) && (cnt == BIT_LAST) && !rxs;
    assign overrun_evt = push_p && fifo_full && !rd_en;

    // Set events are applied after the clear so a coincident event keeps the flag high.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (err_clear) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (stop_bad)
                frame_err <= 1'b1;
            if (overrun_evt)
                overrun <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_p),
        .pop   (rd_en),
        .din   (shift_reg),
        .dout  (rx_data),
        .count (rx_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frame-level reference model checked every cycle plus literal checks.
module tb_uart_receiver;

    localparam int CPB   = 104;
    localparam int DEPTH = 8;
    // rxd fall -> FIFO write edge: 2 sync + 1 edge detect + half bit + 9 bits + 1 push register.
    localparam int LAT   = 2 + 1 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mq[$];
    bit         m_fe = 1'b0;
    bit         m_ov = 1'b0;
    bit         pend_valid = 1'b0;
    bit         pend_ok = 1'b0;
    int         pend_cyc = 0;
    logic [7:0] pend_byte = 8'h00;

    uart_receiver #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .err_clear (err_clear),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input bit pop_at_push);
        rxd       = 1'b0;
        pend_byte = b;
        pend_ok   = stop_ok;
        pend_cyc  = cyc + LAT;
        pend_valid = 1'b1;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop_ok;
        if (pop_at_push) begin
            tick(LAT - 1 - 9 * CPB);
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
            tick(10 * CPB - LAT);
        end else begin
            tick(CPB);
        end
        rxd = 1'b1;
        tick(CPB / 2);
    endtask

    initial begin
        fork
            begin : model
                int sz;
                bit pop;
                forever begin
                    @(posedge clk);
                    cyc++;
                    if (reset) begin
                        mq.delete();
                        m_fe = 1'b0;
                        m_ov = 1'b0;
                        pend_valid = 1'b0;
                    end else begin
                        sz  = mq.size();
                        pop = rd_en && (sz > 0);
                        if (err_clear) begin
                            m_fe = 1'b0;
                            m_ov = 1'b0;
                        end
                        if (pop)
                            void'(mq.pop_front());
                        if (pend_valid && !pend_ok && cyc == pend_cyc - 1) begin
                            m_fe = 1'b1;
                            pend_valid = 1'b0;
                        end
                        if (pend_valid && pend_ok && cyc == pend_cyc) begin
                            if (sz == DEPTH && !pop)
                                m_ov = 1'b1;
                            else
                                mq.push_back(pend_byte);
                            pend_valid = 1'b0;
                        end
                    end
                end
            end
            begin : compare
                forever begin
                    @(negedge clk);
                    if (cyc > 0) begin
                        check("rx_valid", {31'd0, rx_valid}, {31'd0, mq.size() != 0});
                        check("rx_count", {28'd0, rx_count}, mq.size());
                        check("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
                        check("overrun", {31'd0, overrun}, {31'd0, m_ov});
                        if (mq.size() > 0)
                            check("rx_data", {24'd0, rx_data}, {24'd0, mq[0]});
                    end
                end
            end
            begin : watchdog
                #5_000_000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        tick(4);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_count", {28'd0, rx_count}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        tick(CPB);

        // Single clean frame
        send(8'hA5, 1'b1, 1'b0);
        check("a5_valid", {31'd0, rx_valid}, 32'd1);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_count", {28'd0, rx_count}, 32'd1);
        check("model_a5", {24'd0, mq[0]}, 32'hA5);
        pop_one();
        check("a5_pop_valid", {31'd0, rx_valid}, 32'd0);
        check("a5_pop_count", {28'd0, rx_count}, 32'd0);

        // Short glitch on idle line
        rxd = 1'b0;
        tick(30);
        rxd = 1'b1;
        tick(2 * CPB);
        check("glitch_count", {28'd0, rx_count}, 32'd0);
        check("glitch_ferr", {31'd0, frame_err}, 32'd0);

        // Framing error, then recovery and clear
        send(8'h3C, 1'b0, 1'b0);
        check("fe_flag", {31'd0, frame_err}, 32'd1);
        check("fe_count", {28'd0, rx_count}, 32'd0);
        send(8'h11, 1'b1, 1'b0);
        check("fe_next_data", {24'd0, rx_data}, 32'h11);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("fe_cleared", {31'd0, frame_err}, 32'd0);
        pop_one();

        // Overrun: nine bytes into an eight-entry FIFO
        for (int i = 0; i < 9; i++)
            send(8'(i), 1'b1, 1'b0);
        check("ovr_count", {28'd0, rx_count}, 32'd8);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("model_ovr_size", mq.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("ovr_order", {24'd0, rx_data}, i);
            pop_one();
        end
        check("ovr_drained", {28'd0, rx_count}, 32'd0);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;

        // Full FIFO with pop in the exact push cycle
        for (int i = 0; i < 8; i++)
            send(8'h10 + 8'(i), 1'b1, 1'b0);
        send(8'h99, 1'b1, 1'b1);
        check("pp_count", {28'd0, rx_count}, 32'd8);
        check("pp_ovr", {31'd0, overrun}, 32'd0);
        check("pp_head", {24'd0, rx_data}, 32'h11);
        for (int i = 0; i < 7; i++)
            pop_one();
        check("pp_tail", {24'd0, rx_data}, 32'h99);
        check("pp_tail_count", {28'd0, rx_count}, 32'd1);

        // Reset in the middle of data bit 4, with a flag set and a byte queued
        send(8'h77, 1'b0, 1'b0);
        check("pre_abort_ferr", {31'd0, frame_err}, 32'd1);
        rxd = 1'b0;
        pend_byte = 8'hC3;
        pend_ok   = 1'b1;
        pend_cyc  = cyc + LAT;
        pend_valid = 1'b1;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = pend_byte[i];
            tick(CPB);
        end
        rxd = pend_byte[4];
        tick(CPB / 2);
        reset = 1'b1;
        rxd   = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(LAT);
        check("abort_valid", {31'd0, rx_valid}, 32'd0);
        check("abort_count", {28'd0, rx_count}, 32'd0);
        check("abort_ferr", {31'd0, frame_err}, 32'd0);
        check("abort_ovr", {31'd0, overrun}, 32'd0);

        send(8'h5A, 1'b1, 1'b0);
        check("post_abort_data", {24'd0, rx_data}, 32'h5A);
        check("post_abort_count", {28'd0, rx_count}, 32'd1);
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
